spi_target: RTL
===============

Name: spi_target

Overview:
- SPI responder (target) that lets an external SPI initiator read and write a 128-entry, 8-bit register space inside the FPGA.
- It is the counterpart of the CPU-side SPI initiator: same wire set, mode 3 (SCK idle high, sample on rising edge, shift on falling edge), MSB first.
- SCK, SS and SDI are oversampled in the CLK1 domain. The block presents a single-cycle strobe interface to a local register file.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers for SPI_SCK, SPI_SS and SPI_SDI (minimum 2).
- AUTO_INC, 1, when 1 the address increments after each data byte in a burst; when 0 the address holds.

Ports:
- CLK1  input  1  system clock; all logic is on its rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- SPI_SCK  input  1  initiator clock; asynchronous to CLK1.
- SPI_SS  input  1  active-low target select.
- SPI_SDI  input  1  initiator-to-target data.
- SPI_SDO  output  1  target-to-initiator data.
- SPI_SDO_OE  output  1  output enable for the SDO pad; 1 = drive.
- REG_ADDR  output  7  register address.
- REG_WDATA  output  8  write data.
- REG_WR  output  1  one-cycle write strobe.
- REG_RD  output  1  one-cycle read strobe.
- REG_RDATA  input  8  read data, valid on the cycle after REG_RD.
- BUSY  output  1  high while SS is asserted (after synchronisation).

Behaviour:
- Reset (asynchronous, active low):
  - state=IDLE, bit count=0, shift registers=0.
  - SPI_SDO=1, SPI_SDO_OE=0, REG_ADDR=0, REG_WDATA=0.
  - REG_WR=0, REG_RD=0, BUSY=0.
- Input conditioning:
  - SCK, SS and SDI each pass through SYNC_STAGES flops.
  - SCK rise and fall are edge-detected on the synchronised signal.
  - SDI is sampled from the synchronised value on the cycle a rise is detected.
- Timing constraint: SCK high and low times must each be at least 4 CLK1 cycles. Slower SCK is always legal.
- Transaction framing:
  - Byte 0 is the command: bit7 = R/W (1 = read), bits[6:0] = start address.
  - Bytes 1..n are data bytes.
- States:
  - IDLE: SDO_OE=0. A synchronised SS falling edge enters CMD and clears the bit count. BUSY=1.
  - CMD: shift SDI on each rise. On the 8th rise, latch the address into REG_ADDR and the R/W flag, then go to DATA.
    - For a read, REG_RD pulses on the cycle after the 8th rise. REG_RDATA is loaded into the TX shift register on the following cycle.
  - DATA, write: after the 8th rise of each byte, REG_WDATA=byte and REG_WR pulses one cycle with the current REG_ADDR. If AUTO_INC, REG_ADDR increments on the cycle after the strobe.
  - DATA, read: on the 8th rise of each byte, if AUTO_INC, REG_ADDR increments first. REG_RD then pulses for the new address and the TX register reloads 1 cycle later. This prefetches the next byte.
- SDO timing:
  - SDO_OE=1 from the state change into CMD until SS deasserts.
  - SPI_SDO always drives TX[7].
  - TX shifts left on each SCK fall except the first fall of a byte (bit count 0). The loaded MSB is therefore already on the wire before that first fall.
  - During CMD and write bursts, TX=0xFF, so SDO reads 1.
- Address wrap: 0x7F increments to 0x00.
- SS deassert mid-byte: partial byte discarded, no strobe, return to IDLE, SDO_OE=0 on the next cycle. A strobe already issued for a completed byte is not retracted.
- SS deassert after a read prefetch: the extra REG_RD is permitted. Register-file reads have no side effects.
- SCK edges while in IDLE are ignored.
- SS edges shorter than the synchroniser depth are not detected (no requirement).
- Reset mid-transaction: all state clears immediately. A strobe in flight is dropped.

Test Plan:
- Write single: SS low, send 0x05, 0xA5, SS high -> exactly one REG_WR with REG_ADDR=0x05, REG_WDATA=0xA5. REG_RD never asserts. SDO=1 throughout.
- Read burst: SS low, send 0x82, then 2 dummy bytes; register file returns 0x3C@0x02, 0xC3@0x03 -> initiator receives 0x3C, 0xC3. REG_RD pulses for addresses 2, 3, 4.
- Wrap: write 0x7F, data 0x11, 0x22 with AUTO_INC=1 -> REG_WR at 0x7F then 0x00. Repeat with AUTO_INC=0 -> both writes at 0x7F.
- Abort: SS low, 0x10, then 5 bits of data, SS high -> no REG_WR. SDO_OE=0 within SYNC_STAGES+2 cycles. The next transaction works normally.
- Minimum timing: SCK high/low = 4 CLK1 cycles, read 0x81 with 0x5A in the register -> 0x5A received with no bit errors.
- Reset: assert RESET_N=0 mid-byte -> all outputs take reset values asynchronously. After release, a fresh write to 0x01 succeeds.

Source files
------------

// File: rtl/spi_target.sv
`default_nettype none
// ============================================================================
//  Module      : spi_target
//  Description : SPI mode-3 responder giving an external initiator read/write
//                access to a 128 x 8-bit register space. SCK/SS/SDI are
//                oversampled in the CLK1 domain; the register side is a
//                single-cycle strobe interface.
//  Ports       : CLK1, RESET_N        - system clock, async active-low reset
//                SPI_SCK/SS/SDI       - SPI inputs (asynchronous to CLK1)
//                SPI_SDO, SPI_SDO_OE  - SPI output and its pad enable
//                REG_ADDR/WDATA/WR/RD - register-file request side
//                REG_RDATA            - read data, valid the cycle after REG_RD
//                BUSY                 - synchronised SS is asserted
//  Revision    : 1.0  initial release
// ============================================================================
module spi_target #(
    parameter int SYNC_STAGES = 2,
    parameter int AUTO_INC    = 1
) (
    input  logic       CLK1,
    input  logic       RESET_N,
    input  logic       SPI_SCK,
    input  logic       SPI_SS,
    input  logic       SPI_SDI,
    output logic       SPI_SDO,
    output logic       SPI_SDO_OE,
    output logic [6:0] REG_ADDR,
    output logic [7:0] REG_WDATA,
    output logic       REG_WR,
    output logic       REG_RD,
    input  logic [7:0] REG_RDATA,
    output logic       BUSY
);

    // A single-flop synchroniser is never acceptable, so clamp to two.
    localparam int C_STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_CMD  = 2'd1;
    localparam logic [1:0] C_ST_DATA = 2'd2;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [C_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [C_STAGES-1:0] ss_sync_q,  ss_sync_d;
    logic [C_STAGES-1:0] sdi_sync_q, sdi_sync_d;
    logic                sck_prev_q, sck_prev_d;
    logic                ss_prev_q,  ss_prev_d;

    logic [1:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic       rw_q, rw_d;
    logic [6:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       wr_q, wr_d;
    logic       rd_q, rd_d;
    logic       load_q, load_d;

    logic w_sck_s, w_ss_s, w_sdi_s;
    logic w_sck_rise, w_sck_fall, w_ss_fall;
    logic w_active;
    logic w_sdo_oe;

    assign w_sck_s    = sck_sync_q[C_STAGES-1];
    assign w_ss_s     = ss_sync_q[C_STAGES-1];
    assign w_sdi_s    = sdi_sync_q[C_STAGES-1];
    assign w_sck_rise =  w_sck_s & ~sck_prev_q;
    assign w_sck_fall = ~w_sck_s &  sck_prev_q;
    assign w_ss_fall  =  ss_prev_q & ~w_ss_s;

    // Selected and still selected: SCK edges only count in this window.
    assign w_active   = (state_q != C_ST_IDLE) && !w_ss_s;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK1 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= C_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_IDLE: begin
                if (w_ss_fall) begin
                    state_d = C_ST_CMD;
                end
            end
            C_ST_CMD: begin
                if (w_ss_s) begin
                    state_d = C_ST_IDLE;
                end else if (w_sck_rise && (bit_cnt_q == 3'd7)) begin
                    state_d = C_ST_DATA;
                end
            end
            C_ST_DATA: begin
                if (w_ss_s) begin
                    state_d = C_ST_IDLE;
                end
            end
            default: state_d = C_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_sdo_oe = (state_q != C_ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        sck_sync_d = {sck_sync_q[C_STAGES-2:0], SPI_SCK};
        ss_sync_d  = {ss_sync_q[C_STAGES-2:0],  SPI_SS};
        sdi_sync_d = {sdi_sync_q[C_STAGES-2:0], SPI_SDI};
        sck_prev_d = w_sck_s;
        ss_prev_d  = w_ss_s;

        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_d       = 1'b0;
        rd_d       = 1'b0;
        // Register file answers one cycle after REG_RD; capture on that cycle.
        load_d     = rd_q;

        if (state_q == C_ST_IDLE) begin
            if (w_ss_fall) begin
                bit_cnt_d = 3'd0;
                rx_d      = 8'h00;
                tx_d      = 8'hFF;
            end
        end else if (w_active) begin
            if (w_sck_rise) begin
                rx_d      = {rx_q[6:0], w_sdi_s};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    if (state_q == C_ST_CMD) begin
                        addr_d = rx_d[6:0];
                        rw_d   = rx_d[7];
                        rd_d   = rx_d[7];
                    end else if (rw_q) begin
                        // Prefetch the byte for the next 8 clocks.
                        if (AUTO_INC != 0) begin
                            addr_d = addr_q + 7'd1;
                        end
                        rd_d = 1'b1;
                    end else begin
                        wdata_d = rx_d;
                        wr_d    = 1'b1;
                    end
                end
            end

            // The first fall of a byte must not shift: the freshly loaded MSB
            // is already on SDO and the initiator samples it on the next rise.
            // Shifting in ones keeps SDO high when nothing is loaded.
            if (w_sck_fall && (bit_cnt_q != 3'd0)) begin
                tx_d = {tx_q[6:0], 1'b1};
            end

            if (load_q && (state_q == C_ST_DATA) && rw_q) begin
                tx_d = REG_RDATA;
            end
        end

        // Post-write increment follows the strobe, even if SS has just risen.
        if (wr_q && (AUTO_INC != 0)) begin
            addr_d = addr_q + 7'd1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK1 or negedge RESET_N) begin
        if (!RESET_N) begin
            // SCK and SS synchronisers start at their idle (high) level so
            // that reset release never looks like an edge.
            sck_sync_q <= '1;
            ss_sync_q  <= '1;
            sdi_sync_q <= '0;
            sck_prev_q <= 1'b1;
            ss_prev_q  <= 1'b1;
            bit_cnt_q  <= 3'd0;
            rx_q       <= 8'h00;
            // TX holds ones at rest so SDO idles high.
            tx_q       <= 8'hFF;
            rw_q       <= 1'b0;
            addr_q     <= 7'd0;
            wdata_q    <= 8'h00;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            load_q     <= 1'b0;
        end else begin
            sck_sync_q <= sck_sync_d;
            ss_sync_q  <= ss_sync_d;
            sdi_sync_q <= sdi_sync_d;
            sck_prev_q <= sck_prev_d;
            ss_prev_q  <= ss_prev_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            load_q     <= load_d;
        end
    end

    assign SPI_SDO    = tx_q[7];
    assign SPI_SDO_OE = w_sdo_oe;
    assign REG_ADDR   = addr_q;
    assign REG_WDATA  = wdata_q;
    assign REG_WR     = wr_q;
    assign REG_RD     = rd_q;
    assign BUSY       = ~w_ss_s;

endmodule
`default_nettype wire
